// File: rtl/dpi_pattern_gen.sv
// Video timing and test-pattern generator for parallel RGB/DPI panels.
// Free-running h/v counters feed one registered output stage; pattern state changes only between frames.
module dpi_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int FRAME_RATE = 60,
   parameter int COLOR_BITS = 8,
   parameter int POS_BITS   = 11
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2:0]                mode,
   input  logic [3*COLOR_BITS-1:0]   solid_rgb,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      den,
   output logic [COLOR_BITS-1:0]     red,
   output logic [COLOR_BITS-1:0]     green,
   output logic [COLOR_BITS-1:0]     blue,
   output logic [POS_BITS-1:0]       x,
   output logic [POS_BITS-1:0]       y,
   output logic                      frame_start,
   output logic [3:0]                seconds
);

   typedef logic [POS_BITS-1:0] pos_t;

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int FC_W    = (FRAME_RATE > 1) ? $clog2(FRAME_RATE) : 1;

   localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
   localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);
   localparam pos_t H_ACT  = pos_t'(H_ACTIVE);
   localparam pos_t V_ACT  = pos_t'(V_ACTIVE);
   localparam pos_t HS_BEG = pos_t'(H_ACTIVE + H_FP);
   localparam pos_t HS_END = pos_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam pos_t VS_BEG = pos_t'(V_ACTIVE + V_FP);
   localparam pos_t VS_END = pos_t'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [POS_BITS:0]   H_ACT_X = (POS_BITS+1)'(H_ACTIVE);
   localparam logic [POS_BITS:0]   BAR_LEN = (POS_BITS+1)'(16);
   localparam logic [POS_BITS:0]   STEP    = (POS_BITS+1)'(4);
   localparam logic [FC_W-1:0]     FC_LAST = FC_W'(FRAME_RATE - 1);

   // {r,g,b} on/off flags for the eight colour bars, left to right
   function automatic logic [2:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return 3'b111;
         3'd1:    return 3'b110;
         3'd2:    return 3'b011;
         3'd3:    return 3'b010;
         3'd4:    return 3'b101;
         3'd5:    return 3'b100;
         3'd6:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [3*COLOR_BITS-1:0] expand(input logic [2:0] c);
      return {{COLOR_BITS{c[2]}}, {COLOR_BITS{c[1]}}, {COLOR_BITS{c[0]}}};
   endfunction

   pos_t                    h_cnt_p0, v_cnt_p0, bar_off;
   logic [2:0]              mode_q, mode_p0, bar_idx_p0;
   logic [FC_W-1:0]         frame_cnt;
   logic [3:0]              sec_cnt;
   logic                    first_px_p0, last_px_p0, vld_p0, hs_act_p0, vs_act_p0, in_bar_p0;
   logic [POS_BITS:0]       bar_next;
   logic [3*COLOR_BITS-1:0] rgb_p0, rgb_p1;
   logic                    hsync_p1, vsync_p1, vld_p1, frame_start_p1;
   pos_t                    x_p1, y_p1;

   // ---- stage p0: counters and frame-level state ----
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_p0  <= '0;
         v_cnt_p0  <= '0;
         mode_q    <= '0;
         bar_off   <= '0;
         frame_cnt <= '0;
         sec_cnt   <= '0;
      end else begin
         if (h_cnt_p0 == H_LAST) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
         end else begin
            h_cnt_p0 <= h_cnt_p0 + 1'b1;
         end
         if (first_px_p0)
            mode_q <= mode;
         // Frame-level state advances on the last pixel so every pixel of a frame sees one value
         if (last_px_p0) begin
            bar_off <= (bar_next >= H_ACT_X) ? pos_t'(bar_next - H_ACT_X) : pos_t'(bar_next);
            if (frame_cnt == FC_LAST) begin
               frame_cnt <= '0;
               sec_cnt   <= sec_cnt + 1'b1;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      first_px_p0 = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      last_px_p0  = (h_cnt_p0 == H_LAST) && (v_cnt_p0 == V_LAST);
      vld_p0      = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
      hs_act_p0   = (h_cnt_p0 >= HS_BEG) && (h_cnt_p0 < HS_END);
      vs_act_p0   = (v_cnt_p0 >= VS_BEG) && (v_cnt_p0 < VS_END);
      // The first pixel uses the incoming mode directly, since the register only loads on that edge
      mode_p0     = first_px_p0 ? mode : mode_q;
      bar_next    = {1'b0, bar_off} + STEP;
      in_bar_p0   = ({1'b0, h_cnt_p0} >= {1'b0, bar_off}) &&
                    ({1'b0, h_cnt_p0} < ({1'b0, bar_off} + BAR_LEN));
   end

   always_comb begin
      bar_idx_p0 = '0;
      for (int k = 1; k < 8; k++)
         if (h_cnt_p0 >= pos_t'(k * BAR_W))
            bar_idx_p0 = 3'(k);
   end

   always_comb begin
      rgb_p0 = '0;
      if (vld_p0) begin
         case (mode_p0)
            3'd0:    rgb_p0 = solid_rgb;
            3'd1:    rgb_p0 = expand(bar_color(bar_idx_p0));
            3'd2:    rgb_p0 = expand({3{h_cnt_p0[5] ^ v_cnt_p0[5]}});
            3'd3:    rgb_p0 = {h_cnt_p0[COLOR_BITS-1:0], v_cnt_p0[COLOR_BITS-1:0], COLOR_BITS'(frame_cnt)};
            3'd4:    rgb_p0 = expand({3{in_bar_p0}});
            default: rgb_p0 = '0;
         endcase
      end
   end

   // ---- stage p1: registered outputs ----
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_p1       <= ~HS_POL;
         vsync_p1       <= ~VS_POL;
         vld_p1         <= 1'b0;
         rgb_p1         <= '0;
         x_p1           <= '0;
         y_p1           <= '0;
         frame_start_p1 <= 1'b0;
      end else begin
         hsync_p1       <= hs_act_p0 ? HS_POL : ~HS_POL;
         vsync_p1       <= vs_act_p0 ? VS_POL : ~VS_POL;
         vld_p1         <= vld_p0;
         rgb_p1         <= rgb_p0;
         x_p1           <= h_cnt_p0;
         y_p1           <= v_cnt_p0;
         frame_start_p1 <= first_px_p0;
      end
   end

   assign hsync       = hsync_p1;
   assign vsync       = vsync_p1;
   assign den         = vld_p1;
   assign red         = rgb_p1[3*COLOR_BITS-1:2*COLOR_BITS];
   assign green       = rgb_p1[2*COLOR_BITS-1:COLOR_BITS];
   assign blue        = rgb_p1[COLOR_BITS-1:0];
   assign x           = x_p1;
   assign y           = y_p1;
   assign frame_start = frame_start_p1;
   assign seconds     = sec_cnt;

endmodule

// File: tb/tb_dpi_pattern_gen.sv
// Bench for dpi_pattern_gen: scaled-down timing, expected outputs derived from frame arithmetic.
// A second tiny instance exercises the seconds counter.
module tb_dpi_pattern_gen;

   localparam int HA = 64, HFP = 2, HSW = 4, HBP = 2, HT = HA + HFP + HSW + HBP;
   localparam int VA = 34, VFP = 1, VSW = 1, VBP = 1, VT = VA + VFP + VSW + VBP;
   localparam int F  = HT * VT;
   localparam int FR = 3;
   localparam logic [53:0] RST_VEC = {2'b11, 52'd0};

   logic        clk = 1'b0;
   logic        reset, rst2;
   logic [2:0]  mode, mode2;
   logic [23:0] solid_rgb, solid2;

   logic        hsync, vsync, den, frame_start;
   logic [7:0]  red, green, blue;
   logic [10:0] x, y;
   logic [3:0]  seconds;

   logic        hsync2, vsync2, den2, frame_start2;
   logic [7:0]  red2, green2, blue2;
   logic [10:0] x2, y2;
   logic [3:0]  seconds2;

   logic [53:0] got;
   logic [23:0] rgb;
   assign got = {hsync, vsync, den, red, green, blue, x, y, frame_start, seconds};
   assign rgb = {red, green, blue};

   int tests = 0;
   int fails = 0;

   // Model state: n = counter position (edges since reset), pos = position shown on the outputs
   int          n = 0;
   int          pos = -1;
   logic [2:0]  cur_mode = 3'd0;
   logic [23:0] exp_solid = 24'd0;

   always #5 clk = ~clk;

   dpi_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_RATE(FR), .COLOR_BITS(8), .POS_BITS(11)
   ) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
      .hsync(hsync), .vsync(vsync), .den(den), .red(red), .green(green), .blue(blue),
      .x(x), .y(y), .frame_start(frame_start), .seconds(seconds)
   );

   dpi_pattern_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_RATE(2), .COLOR_BITS(8), .POS_BITS(11)
   ) u_small (
      .clk(clk), .reset(rst2), .mode(mode2), .solid_rgb(solid2),
      .hsync(hsync2), .vsync(vsync2), .den(den2), .red(red2), .green(green2), .blue(blue2),
      .x(x2), .y(y2), .frame_start(frame_start2), .seconds(seconds2)
   );

   function automatic logic [23:0] bar_rgb(input int idx);
      case (idx)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [53:0] expv();
      int eh, ev, fr, idx, bs;
      logic hs, vs, de, fs;
      logic [23:0] c;
      logic [3:0] sec;
      sec = 4'(((n / F) / FR) % 16);
      if (pos < 0) return {2'b11, 48'd0, sec};
      eh = (pos % F) % HT;
      ev = (pos % F) / HT;
      fr = pos / F;
      de = (eh < HA) && (ev < VA);
      hs = !((eh >= HA + HFP) && (eh < HA + HFP + HSW));
      vs = !((ev >= VA + VFP) && (ev < VA + VFP + VSW));
      fs = ((pos % F) == 0);
      c = 24'd0;
      if (de) begin
         case (cur_mode)
            3'd0: c = exp_solid;
            3'd1: begin
               idx = eh / (HA / 8);
               if (idx > 7) idx = 7;
               c = bar_rgb(idx);
            end
            3'd2: c = ((((eh / 32) + (ev / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
            3'd3: c = {8'(eh % 256), 8'(ev % 256), 8'((fr % FR) % 256)};
            3'd4: begin
               bs = (4 * fr) % HA;
               c = (eh >= bs && eh < bs + 16) ? 24'hFFFFFF : 24'h0;
            end
            default: c = 24'h0;
         endcase
      end
      return {hs, vs, de, c, 11'(eh), 11'(ev), fs, sec};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         n = 0;
         pos = -1;
      end else begin
         pos = n;
         if (n % F == 0) cur_mode = mode;
         n = n + 1;
      end
      exp_solid = solid_rgb;
      #1;
   endtask

   task automatic test_reset();
      int c, den_hi, hs_first, hs_len;
      reset = 1'b1;
      mode = 3'd0;
      solid_rgb = 24'($urandom);
      repeat (3) begin
         tick();
         tests++;
         if (got !== RST_VEC) begin
            fails++;
            $display("FAIL reset_state got=%h exp=%h", got, RST_VEC);
         end
      end
      reset = 1'b0;
      c = 0;
      while (c < 4 && den !== 1'b1) begin
         tick();
         c++;
      end
      tests++;
      if (c !== 1) begin
         fails++;
         $display("FAIL den_first_rise cycles=%0d exp=1", c);
      end
      den_hi = 0; hs_first = -1; hs_len = 0;
      for (int i = 0; i < HT; i++) begin
         if (i > 0) tick();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL line0 i=%0d got=%h exp=%h", i, got, expv());
         end
         if (den) den_hi++;
         if (!hsync) begin
            if (hs_first < 0) hs_first = i;
            hs_len++;
         end
      end
      tests++;
      if (den_hi !== HA) begin
         fails++;
         $display("FAIL den_width got=%0d exp=%0d", den_hi, HA);
      end
      tests++;
      if (hs_first !== HA + HFP || hs_len !== HSW) begin
         fails++;
         $display("FAIL hsync_window start=%0d len=%0d exp=%0d/%0d", hs_first, hs_len, HA + HFP, HSW);
      end
      tick();
      tests++;
      if (den !== 1'b1 || x !== 11'd0 || y !== 11'd1) begin
         fails++;
         $display("FAIL line1_start den=%b x=%0d y=%0d exp 1/0/1", den, x, y);
      end
   endtask

   task automatic test_frame_timing();
      int fs_seen, last, vs_low, vs_first_ok;
      fs_seen = 0; last = 0; vs_low = 0; vs_first_ok = 0;
      solid_rgb = 24'($urandom);
      for (int i = 0; i < 2 * F + HT; i++) begin
         tick();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL frame_cyc i=%0d got=%h exp=%h", i, got, expv());
         end
         if (!den && rgb !== 24'd0) begin
            fails++;
            $display("FAIL blank_rgb x=%0d y=%0d rgb=%h exp=0", x, y, rgb);
         end
         if (frame_start) begin
            if (fs_seen > 0) begin
               tests++;
               if (i - last !== F) begin
                  fails++;
                  $display("FAIL frame_period got=%0d exp=%0d", i - last, F);
               end
            end
            last = i;
            fs_seen++;
            if (fs_seen == 2) break;
         end
         if (fs_seen == 1 && !vsync) begin
            if (vs_low == 0 && x == 11'd0 && y == 11'(VA + VFP)) vs_first_ok = 1;
            vs_low++;
         end
      end
      tests++;
      if (fs_seen !== 2 || vs_low !== VSW * HT || vs_first_ok !== 1) begin
         fails++;
         $display("FAIL vsync_window frames=%0d low=%0d aligned=%0d exp 2/%0d/1", fs_seen, vs_low, vs_first_ok, VSW * HT);
      end
   endtask

   task automatic test_bars_and_switch();
      int seen, sw_x, done;
      seen = 0; done = 0;
      sw_x = $urandom_range(0, HT - 1);
      mode = 3'd1;
      for (int i = 0; i < 3 * F; i++) begin
         tick();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL bars_cyc x=%0d y=%0d got=%h exp=%h", x, y, got, expv());
         end
         if (frame_start) seen++;
         if (seen == 1 && y == 11'd0 && (x == 11'd0 || x == 11'(HA / 8) || x == 11'(HA - 1))) begin
            tests++;
            if (rgb !== (x == 11'd0 ? 24'hFFFFFF : (x == 11'(HA / 8) ? 24'hFFFF00 : 24'h000000))) begin
               fails++;
               $display("FAIL bar_pixel x=%0d rgb=%h", x, rgb);
            end
         end
         if (seen == 1 && y == 11'd10 && x == 11'(sw_x)) mode = 3'd2;
         if (seen == 1 && y == 11'd20 && x == 11'(HA / 8)) begin
            tests++;
            if (rgb !== 24'hFFFF00) begin
               fails++;
               $display("FAIL no_tear rgb=%h exp=ffff00", rgb);
            end
         end
         if (seen == 2 && x == 11'd32 && (y == 11'd0 || y == 11'd32)) begin
            tests++;
            if (rgb !== (y == 11'd0 ? 24'hFFFFFF : 24'h000000)) begin
               fails++;
               $display("FAIL checker y=%0d rgb=%h", y, rgb);
            end
            if (y == 11'd32) begin
               done = 1;
               break;
            end
         end
      end
      tests++;
      if (done !== 1) begin
         fails++;
         $display("FAIL bars_timeout seen=%0d exp=2", seen);
      end
   endtask

   task automatic test_solid_gradient();
      int frames;
      frames = 0;
      mode = 3'd0;
      for (int i = 0; i < 3 * F + 10; i++) begin
         solid_rgb = 24'($urandom);
         tick();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL solid_grad x=%0d y=%0d mode=%0d got=%h exp=%h", x, y, cur_mode, got, expv());
         end
         if (frames == 2 && x == 11'(HA - 1) && y == 11'(VA - 1)) begin
            tests++;
            if (red !== 8'(HA - 1) || green !== 8'(VA - 1)) begin
               fails++;
               $display("FAIL gradient_corner r=%0d g=%0d exp=%0d/%0d", red, green, HA - 1, VA - 1);
            end
         end
         if (frame_start) begin
            frames++;
            if (frames == 1) mode = 3'd3;
            if (frames == 3) break;
         end
      end
      tests++;
      if (frames !== 3) begin
         fails++;
         $display("FAIL solid_grad_timeout frames=%0d exp=3", frames);
      end
   endtask

   task automatic test_moving_bar();
      int k, bs, done;
      k = -1; done = 0;
      mode = 3'd4;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 17 * F + 10; i++) begin
         tick();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL movbar_cyc x=%0d y=%0d got=%h exp=%h", x, y, got, expv());
         end
         if (frame_start) k++;
         if (k >= 0 && y == 11'd0 && den) begin
            bs = (4 * k) % HA;
            if (x == 11'(bs) || (x == 11'(bs + 16) && bs + 16 < HA)) begin
               tests++;
               if (rgb !== (x == 11'(bs) ? 24'hFFFFFF : 24'h0)) begin
                  fails++;
                  $display("FAIL bar_edge frame=%0d x=%0d rgb=%h", k, x, rgb);
               end
            end
            if (k == 15 && x == 11'd0) begin
               tests++;
               if (rgb !== 24'h0) begin
                  fails++;
                  $display("FAIL bar_nowrap rgb=%h exp=0", rgb);
               end
            end
         end
         if (k == 16 && y == 11'd1) begin
            done = 1;
            break;
         end
      end
      tests++;
      if (done !== 1) begin
         fails++;
         $display("FAIL movbar_timeout frames=%0d exp=16", k);
      end
   endtask

   task automatic test_mid_reset();
      int tx, ty, hit;
      tx = $urandom_range(0, HA - 1);
      ty = $urandom_range(1, VA - 1);
      hit = 0;
      mode = 3'd3;
      for (int i = 0; i < 2 * F; i++) begin
         tick();
         if (x == 11'(tx) && y == 11'(ty) && !frame_start) begin
            hit = 1;
            break;
         end
      end
      tests++;
      if (hit !== 1) begin
         fails++;
         $display("FAIL midreset_timeout target=%0d,%0d", tx, ty);
      end
      reset = 1'b1;
      tick();
      tests++;
      if (got !== RST_VEC) begin
         fails++;
         $display("FAIL midreset_state got=%h exp=%h", got, RST_VEC);
      end
      reset = 1'b0;
      tick();
      tests++;
      if (frame_start !== 1'b1 || seconds !== 4'd0 || x !== 11'd0 || y !== 11'd0 || den !== 1'b1) begin
         fails++;
         $display("FAIL midreset_restart fs=%b sec=%0d x=%0d y=%0d den=%b", frame_start, seconds, x, y, den);
      end
      for (int i = 0; i < F / 2; i++) begin
         tick();
         tests++;
         if (got !== expv()) begin
            fails++;
            $display("FAIL midreset_cyc x=%0d y=%0d got=%h exp=%h", x, y, got, expv());
         end
      end
   endtask

   task automatic test_seconds_wrap();
      int k, last;
      k = 0; last = 0;
      rst2 = 1'b0;
      for (int i = 0; i < 33 * 84 + 20; i++) begin
         tick();
         if (frame_start2) begin
            if (k > 0) begin
               tests++;
               if (i - last !== 84) begin
                  fails++;
                  $display("FAIL small_period got=%0d exp=84", i - last);
               end
            end
            tests++;
            if (seconds2 !== 4'((k / 2) % 16)) begin
               fails++;
               $display("FAIL seconds frame=%0d got=%0d exp=%0d", k, seconds2, (k / 2) % 16);
            end
            last = i;
            k++;
            if (k == 33) break;
         end
      end
      tests++;
      if (k !== 33) begin
         fails++;
         $display("FAIL seconds_timeout frames=%0d exp=33", k);
      end
   endtask

   initial begin
      reset = 1'b1;
      rst2 = 1'b1;
      mode = 3'd0;
      mode2 = 3'd1;
      solid_rgb = 24'd0;
      solid2 = 24'h123456;
      test_reset();
      test_frame_timing();
      test_bars_and_switch();
      test_solid_gradient();
      test_moving_bar();
      test_mid_reset();
      test_seconds_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
